// File: rtl/axis_traffic_gen.sv
// AXI4-Stream traffic generator: emits runs of fixed-length packets with
// programmable inter-packet gap and one of four data patterns.
module axis_traffic_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [LEN_WIDTH-1:0]  i_cfg_len,
    input  logic [LEN_WIDTH-1:0]  i_cfg_npkts,
    input  logic [GAP_WIDTH-1:0]  i_cfg_gap,
    input  logic [1:0]            i_cfg_mode,
    input  logic [31:0]           i_cfg_seed,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_tlast,
    output logic                  o_tuser,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LEN_WIDTH-1:0]  o_pkt_cnt
);

    localparam int EXT_W   = DATA_WIDTH + LEN_WIDTH + 32;
    localparam int N_BYTES = DATA_WIDTH / 8;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_npkts;
    logic [GAP_WIDTH-1:0]   r_gap;
    logic [1:0]             r_mode;
    logic [31:0]            r_seed;
    logic [LEN_WIDTH-1:0]   r_beat;
    logic [31:0]            r_cnt32;
    logic [31:0]            r_lfsr;
    logic [GAP_WIDTH-1:0]   r_gap_cnt;
    logic [LEN_WIDTH-1:0]   r_pkt_cnt;
    logic                   r_stop_seen;
    logic                   r_done;

    logic                   w_start_acc;
    logic                   w_run_end;
    logic                   w_hs;
    logic                   w_is_last;
    logic                   w_stop;
    logic [LEN_WIDTH-1:0]   w_len_eff;
    logic [LEN_WIDTH-1:0]   w_pkt_inc;
    logic [31:0]            w_lfsr_next;
    logic [31:0]            w_pat32;
    logic [DATA_WIDTH-1:0]  w_rep;
    logic [EXT_W-1:0]       w_ext_beat;
    logic [EXT_W-1:0]       w_ext_cnt;

    assign w_len_eff   = (r_len == '0) ? LEN_WIDTH'(1) : r_len;
    assign w_is_last   = (r_beat == w_len_eff - LEN_WIDTH'(1));
    assign w_hs        = (r_state == S_SEND) && i_tready;
    assign w_stop      = r_stop_seen | i_stop;
    assign w_pkt_inc   = r_pkt_cnt + LEN_WIDTH'(1);
    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        w_run_end    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // the done cycle belongs to the previous run, so start waits
                if (i_start && !r_done) begin
                    w_state_next = S_SEND;
                    w_start_acc  = 1'b1;
                end
            end
            S_SEND: begin
                if (w_hs && w_is_last) begin
                    if (w_stop || (r_npkts != '0 && w_pkt_inc == r_npkts)) begin
                        w_state_next = S_IDLE;
                        w_run_end    = 1'b1;
                    end else if (r_gap != '0) begin
                        w_state_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (w_stop) begin
                    w_state_next = S_IDLE;
                    w_run_end    = 1'b1;
                end else if (r_gap_cnt <= GAP_WIDTH'(1)) begin
                    w_state_next = S_SEND;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_npkts     <= '0;
            r_gap       <= '0;
            r_mode      <= '0;
            r_seed      <= '0;
            r_beat      <= '0;
            r_cnt32     <= '0;
            r_lfsr      <= 32'h1;
            r_gap_cnt   <= '0;
            r_pkt_cnt   <= '0;
            r_stop_seen <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_run_end;
            if (w_start_acc) begin
                r_len       <= i_cfg_len;
                r_npkts     <= i_cfg_npkts;
                r_gap       <= i_cfg_gap;
                r_mode      <= i_cfg_mode;
                r_seed      <= i_cfg_seed;
                r_beat      <= '0;
                r_cnt32     <= '0;
                r_lfsr      <= (i_cfg_seed == '0) ? 32'h1 : i_cfg_seed;
                r_pkt_cnt   <= '0;
                r_stop_seen <= 1'b0;
            end else begin
                if (w_run_end) begin
                    r_stop_seen <= 1'b0;
                end else if (r_state != S_IDLE && i_stop) begin
                    r_stop_seen <= 1'b1;
                end
                if (w_hs) begin
                    r_beat  <= w_is_last ? '0 : r_beat + LEN_WIDTH'(1);
                    r_cnt32 <= r_cnt32 + 32'd1;
                    r_lfsr  <= w_lfsr_next;
                    if (w_is_last) begin
                        r_pkt_cnt <= w_pkt_inc;
                    end
                end
                if (w_hs && w_is_last && w_state_next == S_GAP) begin
                    r_gap_cnt <= r_gap;
                end else if (r_state == S_GAP) begin
                    r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
                end
            end
        end
    end

    // 32-bit pattern replicated byte-wise so any multiple-of-8 width is filled
    assign w_pat32 = (r_mode == 2'd2) ? r_lfsr : r_seed;

    generate
        for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_rep
            assign w_rep[gi*8 +: 8] = w_pat32[(gi%4)*8 +: 8];
        end
    endgenerate

    assign w_ext_beat = {{(EXT_W-LEN_WIDTH){1'b0}}, r_beat};
    assign w_ext_cnt  = {{(EXT_W-32){1'b0}}, r_cnt32};

    always_comb begin
        o_tdata = w_rep;
        case (r_mode)
            2'd0:    o_tdata = w_ext_beat[DATA_WIDTH-1:0];
            2'd1:    o_tdata = w_ext_cnt[DATA_WIDTH-1:0];
            default: o_tdata = w_rep;
        endcase
    end

    assign o_tvalid  = (r_state == S_SEND);
    assign o_tlast   = (r_state == S_SEND) && w_is_last;
    assign o_tuser   = (r_state == S_SEND) && (r_beat == '0);
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;
    assign o_pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed self-checking bench for axis_traffic_gen: fixed scenarios with
// hand-derived expected beats, gaps, done pulses and packet counts.
module tb_axis_traffic_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_start;
    logic        i_stop;
    logic [15:0] i_cfg_len;
    logic [15:0] i_cfg_npkts;
    logic [7:0]  i_cfg_gap;
    logic [1:0]  i_cfg_mode;
    logic [31:0] i_cfg_seed;
    logic [31:0] o_tdata;
    logic        o_tvalid;
    logic        i_tready;
    logic        o_tlast;
    logic        o_tuser;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_pkt_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axis_traffic_gen dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_cfg_len  (i_cfg_len),
        .i_cfg_npkts(i_cfg_npkts),
        .i_cfg_gap  (i_cfg_gap),
        .i_cfg_mode (i_cfg_mode),
        .i_cfg_seed (i_cfg_seed),
        .o_tdata    (o_tdata),
        .o_tvalid   (o_tvalid),
        .i_tready   (i_tready),
        .o_tlast    (o_tlast),
        .o_tuser    (o_tuser),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_pkt_cnt  (o_pkt_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 32'h8020_0003;
        return y;
    endfunction

    initial begin
        int cyc;
        int hs;
        int low_run;
        int gap_low;
        logic [31:0] exp_d;

        rstn = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_tready = 1'b1;
        i_cfg_len = '0; i_cfg_npkts = '0; i_cfg_gap = '0; i_cfg_mode = '0; i_cfg_seed = '0;
        step(); step();
        chk("rst_tvalid", o_tvalid, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_pkt_cnt", o_pkt_cnt, 16'd0);
        chk("rst_tdata", o_tdata, 32'd0);
        chk("rst_tlast_tuser", {o_tlast, o_tuser}, 2'b00);
        rstn = 1'b1;
        step();

        // len 4, 2 packets, no gap, beat-index data
        i_cfg_len = 16'd4; i_cfg_npkts = 16'd2; i_cfg_gap = 8'd0; i_cfg_mode = 2'd0;
        do_start();
        for (int i = 0; i < 8; i++) begin
            chk("t1_tvalid", o_tvalid, 1'b1);
            chk("t1_tdata", o_tdata, 32'(i % 4));
            chk("t1_tuser", o_tuser, (i % 4) == 0);
            chk("t1_tlast", o_tlast, (i % 4) == 3);
            step();
        end
        chk("t1_done", o_done, 1'b1);
        chk("t1_busy", o_busy, 1'b0);
        chk("t1_tvalid_end", o_tvalid, 1'b0);
        chk("t1_pkt_cnt", o_pkt_cnt, 16'd2);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("t1_start_in_done_ignored", o_busy, 1'b0);
        chk("t1_done_one_cycle", o_done, 1'b0);
        step();

        // len 3, 2 packets, gap 2, counter data, tready 1010...
        i_cfg_len = 16'd3; i_cfg_npkts = 16'd2; i_cfg_gap = 8'd2; i_cfg_mode = 2'd1;
        do_start();
        exp_d = 0; hs = 0; low_run = 0; gap_low = -1; cyc = 0;
        while (o_busy && cyc < 60) begin
            i_tready = (cyc % 2 == 0);
            if (o_tvalid) begin
                chk("t2_tdata", o_tdata, exp_d);
                if (hs == 3 && gap_low < 0) gap_low = low_run;
                low_run = 0;
                if (i_tready) begin
                    exp_d++;
                    hs++;
                end
            end else begin
                low_run++;
            end
            step();
            cyc++;
        end
        chk("t2_timeout", cyc < 60, 1'b1);
        chk("t2_beats", hs, 6);
        chk("t2_gap_cycles", gap_low, 2);
        chk("t2_done", o_done, 1'b1);
        chk("t2_pkt_cnt", o_pkt_cnt, 16'd2);
        i_tready = 1'b1;
        step();

        // LFSR with zero seed, one stall mid-packet
        i_cfg_len = 16'd5; i_cfg_npkts = 16'd1; i_cfg_gap = 8'd0; i_cfg_mode = 2'd2; i_cfg_seed = 32'd0;
        do_start();
        chk("t3_first_beat", o_tdata, 32'h1);
        exp_d = 32'h1; hs = 0; cyc = 0;
        while (o_busy && cyc < 30) begin
            i_tready = (cyc != 1 && cyc != 2);
            if (o_tvalid) begin
                chk("t3_tdata", o_tdata, exp_d);
                if (i_tready) begin
                    exp_d = lfsr_step(exp_d);
                    hs++;
                end
            end
            step();
            cyc++;
        end
        chk("t3_timeout", cyc < 30, 1'b1);
        chk("t3_beats", hs, 5);
        chk("t3_done", o_done, 1'b1);
        i_tready = 1'b1;
        step();

        // unlimited run, stop pulse on beat 3 of packet 2
        i_cfg_len = 16'd8; i_cfg_npkts = 16'd0; i_cfg_gap = 8'd0; i_cfg_mode = 2'd0;
        do_start();
        hs = 0; cyc = 0;
        while (o_busy && cyc < 100) begin
            i_stop = 1'b0;
            if (o_tvalid) begin
                chk("t4_tdata", o_tdata, 32'(hs % 8));
                if (hs == 10) i_stop = 1'b1;
                hs++;
            end
            step();
            cyc++;
        end
        i_stop = 1'b0;
        chk("t4_timeout", cyc < 100, 1'b1);
        chk("t4_beats", hs, 16);
        chk("t4_done", o_done, 1'b1);
        chk("t4_pkt_cnt", o_pkt_cnt, 16'd2);
        step();

        // len 0 -> single-beat packets, constant data; cfg changes ignored mid-run
        i_cfg_len = 16'd0; i_cfg_npkts = 16'd3; i_cfg_gap = 8'd0; i_cfg_mode = 2'd3; i_cfg_seed = 32'hA5A5A5A5;
        do_start();
        i_cfg_seed = 32'h12345678; i_cfg_len = 16'd4;
        for (int i = 0; i < 3; i++) begin
            chk("t5_tvalid", o_tvalid, 1'b1);
            chk("t5_tdata", o_tdata, 32'hA5A5A5A5);
            chk("t5_tuser_tlast", {o_tuser, o_tlast}, 2'b11);
            step();
        end
        chk("t5_done", o_done, 1'b1);
        chk("t5_pkt_cnt", o_pkt_cnt, 16'd3);
        step();

        // stop during gap ends the run next cycle
        i_cfg_len = 16'd2; i_cfg_npkts = 16'd0; i_cfg_gap = 8'd5; i_cfg_mode = 2'd0;
        do_start();
        step();
        step();
        chk("t6_gap_tvalid", o_tvalid, 1'b0);
        chk("t6_gap_busy", o_busy, 1'b1);
        step();
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        chk("t6_busy", o_busy, 1'b0);
        chk("t6_done", o_done, 1'b1);
        chk("t6_pkt_cnt", o_pkt_cnt, 16'd1);
        step();

        // reset mid-packet while stalled
        i_cfg_len = 16'd4; i_cfg_npkts = 16'd0; i_cfg_gap = 8'd0; i_cfg_mode = 2'd1;
        i_tready = 1'b0;
        do_start();
        step();
        chk("t7_stalled_tvalid", o_tvalid, 1'b1);
        chk("t7_stalled_tdata", o_tdata, 32'd0);
        rstn = 1'b0;
        step();
        chk("t7_rst_tvalid", o_tvalid, 1'b0);
        chk("t7_rst_busy", o_busy, 1'b0);
        chk("t7_rst_done", o_done, 1'b0);
        rstn = 1'b1;
        step();
        chk("t7_post_done", o_done, 1'b0);
        chk("t7_post_busy", o_busy, 1'b0);
        i_tready = 1'b1;
        do_start();
        chk("t7_restart_tvalid", o_tvalid, 1'b1);
        chk("t7_restart_tdata", o_tdata, 32'd0);
        chk("t7_restart_tuser", o_tuser, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
